// File: rtl/sub16_serial_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// default operand/slice widths.
package sub16_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned W_DEFAULT     = 16;
  localparam int unsigned SLICE_DEFAULT = 4;

endpackage

// File: rtl/sub4.sv
// Combinational slice subtractor: d = x - y - bin, with the borrow out of the
// top bit. N defaults to 4 and matches the serial engine's SLICE.
module sub4 #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);

  logic [N:0] diff;

  // One extra bit catches the borrow leaving the slice.
  always_comb begin
    diff = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bin};
    d    = diff[N-1:0];
    bout = diff[N];
  end

endmodule

// File: rtl/sub16_serial.sv
// Serial W-bit subtractor: d = a - b - bin, processed SLICE bits per cycle,
// LSB first, using one shared slice subtractor.
// Optional feature macro: SUB16_SERIAL_FLAGS_EN adds zero and ovf outputs.
// Assumes W is a multiple of SLICE and W/SLICE >= 2.
module sub16_serial
  import sub16_serial_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned SLICE = SLICE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout
`ifdef SUB16_SERIAL_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  localparam int unsigned NS = W / SLICE;
  localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             br;
  logic [W-1:0]     part;
  logic [SLICE-1:0] s_d;
  logic             s_bout;
  logic [W-1:0]     res_next;

  // Operands shift right each RUN cycle so the active slice is always in the
  // low bits; no variable part-select is needed.
  sub4 #(.N(SLICE)) u_slice (
    .x    (a_q[SLICE-1:0]),
    .y    (b_q[SLICE-1:0]),
    .bin  (br),
    .d    (s_d),
    .bout (s_bout)
  );

  // Full result as it stands once the current slice is merged in.
  always_comb begin
    res_next = {s_d, part[W-1:SLICE]};
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      a_q   <= '0;
      b_q   <= '0;
      br    <= 1'b0;
      part  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SUB16_SERIAL_FLAGS_EN
      zero  <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br    <= bin;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q  <= a_q >> SLICE;
          b_q  <= b_q >> SLICE;
          br   <= s_bout;
          part <= res_next;
          k    <= k + 1'b1;
          if (k == K_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            d     <= res_next;
            bout  <= s_bout;
`ifdef SUB16_SERIAL_FLAGS_EN
            zero  <= (res_next == '0);
            // Top slice sits in the low bits here; compare operand and result signs.
            ovf   <= (a_q[SLICE-1] ^ b_q[SLICE-1]) & (a_q[SLICE-1] ^ s_d[SLICE-1]);
`endif
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sub16_serial.md
SUB16_SERIAL -- requirements
Module: sub16_serial

Interface
REQ-001 Parameter W, 16, operand/result width; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, 4, bits processed per cycle.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 start  input  1  request; SHALL be sampled only in IDLE.
REQ-006 a  input  W  minuend; SHALL be captured on the accepted start.
REQ-007 b  input  W  subtrahend; SHALL be captured on the accepted start.
REQ-008 bin  input  1  borrow-in; SHALL be captured on the accepted start.
REQ-009 busy  output  1  SHALL be high in RUN and DONE.
REQ-010 done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 d  output  W  difference a - b - bin, modulo 2^W.
REQ-012 bout  output  1  final borrow-out; SHALL be high when a < b + bin (unsigned).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 SHALL go to RUN, capture a/b/bin, and clear slice index k to 0.
REQ-015 IDLE with start=0 SHALL stay in IDLE.
REQ-016 Each RUN cycle SHALL compute slice k (LSB first) from the captured operands and the registered borrow, store it, register its borrow, then increment k.
REQ-017 RUN SHALL last exactly W/SLICE cycles (4 at defaults), then go to DONE.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 Latency SHALL be fixed: done high in the 5th cycle after the edge that samples start (defaults).
REQ-020 d and bout SHALL update only on entry to DONE and SHALL hold until the next completion.
REQ-021 Partial results SHALL NOT be visible on d.
REQ-022 start in RUN or DONE SHALL be ignored, with no queueing.
REQ-023 Input changes after acceptance SHALL NOT affect the result.
REQ-024 start held continuously SHALL give back-to-back operations with one IDLE cycle between DONE and the next RUN.
REQ-025 Borrow SHALL wrap through all slices: 0x0000 - 0x0001 gives d=0xFFFF, bout=1.

Reset
REQ-026 rst=1 SHALL force IDLE, k=0, busy=0, done=0, d=0, bout=0, and clear all flag outputs, in any state.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-028 rst and start high in the same cycle: rst SHALL win.

Configuration
REQ-029 With SUB16_SERIAL_FLAGS_EN defined, outputs zero (1) and ovf (1) SHALL exist.
REQ-030 zero SHALL be high when the result is 0.
REQ-031 ovf SHALL be high on two's-complement signed overflow of a - b - bin.
REQ-032 zero and ovf SHALL update on entry to DONE and hold like d.
REQ-033 Without SUB16_SERIAL_FLAGS_EN, zero and ovf and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the default W and SLICE constants.
REQ-035 The slice SHALL be a sub-module sub4: 4-bit x, y, borrow-in -> 4-bit difference, borrow-out; purely combinational.
REQ-036 sub16_serial SHALL instantiate exactly one sub4, reused every RUN cycle.

Verification
REQ-037 a=0x1234, b=0x0234, bin=0 -> done in 5th cycle; d=0x1000, bout=0, zero=0, ovf=0.
REQ-038 a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0.
REQ-039 a=0x8000, b=0x0000, bin=1 -> d=0x7FFF, bout=0, ovf=1.
REQ-040 a=b=0xABCD, then a new start with other values pulsed during RUN -> exactly one done; d=0x0000, zero=1; the second start is ignored.
REQ-041 rst for one cycle in the 2nd RUN cycle -> no done; busy=0, d=0 next cycle; a fresh start then completes normally.
REQ-042 start held high for 3 operations -> done pulses spaced 6 cycles apart, each result correct.
